// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: MDOp encodings and FSM states.
// The control unit imports the same package so both sides agree on the opcodes.
package mdu_defs;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int CNT_W = 4;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product / quotient / remainder for the multiply/divide unit.
// The result is packed as {HI, LO}: {product_hi, product_lo} or {remainder, quotient}.
module mdu_arith
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic signed [2*WIDTH-1:0] a_sext;
    logic signed [2*WIDTH-1:0] b_sext;
    logic        [2*WIDTH-1:0] a_zext;
    logic        [2*WIDTH-1:0] b_zext;
    logic        [2*WIDTH-1:0] prod_signed;
    logic        [2*WIDTH-1:0] prod_unsigned;

    assign a_sext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sext = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zext = {{WIDTH{1'b0}}, a};
    assign b_zext = {{WIDTH{1'b0}}, b};

    assign prod_signed   = a_sext * b_sext;
    assign prod_unsigned = a_zext * b_zext;

    // Signed divide works on magnitudes so the most-negative / -1 case falls out
    // naturally (magnitude quotient 2^(W-1) reinterpreted as most-negative).
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] s_divisor;
    logic [WIDTH-1:0] u_divisor;
    logic [WIDTH-1:0] s_quot_mag;
    logic [WIDTH-1:0] s_rem_mag;
    logic [WIDTH-1:0] s_quot;
    logic [WIDTH-1:0] s_rem;
    logic [WIDTH-1:0] u_quot;
    logic [WIDTH-1:0] u_rem;

    assign div_by_zero = (b == '0);

    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // A zero divisor never reaches HI/LO; substitute 1 to keep the dividers defined.
    assign s_divisor = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign u_divisor = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

    assign s_quot_mag = a_mag / s_divisor;
    assign s_rem_mag  = a_mag % s_divisor;
    assign s_quot     = (a_neg ^ b_neg) ? (~s_quot_mag + 1'b1) : s_quot_mag;
    assign s_rem      = a_neg ? (~s_rem_mag + 1'b1) : s_rem_mag;

    assign u_quot = a / u_divisor;
    assign u_rem  = a % u_divisor;

    always_comb begin
        result = '0;
        case (op)
            OP_MULT:  result = prod_signed;
            OP_MULTU: result = prod_unsigned;
            OP_DIV:   result = {s_rem, s_quot};
            OP_DIVU:  result = {u_rem, u_quot};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at acceptance and held pending until the run counter expires.
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e          state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] pending_reg;
    logic               commit_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic [2*WIDTH-1:0] arith_result;
    logic               div_by_zero;
    logic               is_mult;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op          (MDOp),
        .a           (SrcA),
        .b           (SrcB),
        .result      (arith_result),
        .div_by_zero (div_by_zero)
    );

    assign is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            pending_reg <= '0;
            commit_reg  <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        if (is_arith_op(MDOp)) begin
                            state_reg   <= ST_RUN;
                            busy_reg    <= 1'b1;
                            cnt_reg     <= is_mult ? MULT_LOAD : DIV_LOAD;
                            pending_reg <= arith_result;
                            // A zero divisor still burns the full run but leaves HI/LO alone.
                            commit_reg  <= is_mult || !div_by_zero;
                        end else if (MDOp == OP_MTHI) begin
                            hi_reg <= SrcA;
                        end else if (MDOp == OP_MTLO) begin
                            lo_reg <= SrcA;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        if (commit_reg) begin
                            hi_reg <= pending_reg[2*WIDTH-1:WIDTH];
                            lo_reg <= pending_reg[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand sequences for
// mid-run commands, same-edge Start, and asynchronous reset during a divide.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .MDOp  (MDOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive a one-cycle Start; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = 3'd0;
    endtask

    // Counts negedge samples with Busy high; bounded so a stuck Busy cannot hang.
    task automatic count_busy(output int cnt);
        int guard;
        cnt   = 0;
        guard = 0;
        while (Busy === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          cyc;
        int          guard;

        vecs[0]  = '{"mult_neg2x3",    3'd1, 32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"multu_max_sq",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"div_m7_2",       3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7_0",       3'd4, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div_minneg_m1",  3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100_7",     3'd4, 32'h00000064, 32'h00000007, 10, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{"mult_7_m3",      3'd1, 32'h00000007, 32'hFFFFFFFD,  5, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[7]  = '{"multu_2p16sq",   3'd2, 32'h00010000, 32'h00010000,  5, 32'h00000001, 32'h00000000};
        vecs[8]  = '{"div_7_m2",       3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"mthi_1234",      3'd5, 32'h00001234, 32'h00000000,  0, 32'h00001234, 32'hFFFFFFFD};
        vecs[10] = '{"mtlo_55",        3'd6, 32'h00000055, 32'h00000000,  0, 32'h00001234, 32'h00000055};
        vecs[11] = '{"op_none",        3'd0, 32'hDEADBEEF, 32'h00000001,  0, 32'h00001234, 32'h00000055};
        vecs[12] = '{"op_unencoded",   3'd7, 32'hDEADBEEF, 32'h00000001,  0, 32'h00001234, 32'h00000055};
        vecs[13] = '{"divu_max_1",     3'd4, 32'hFFFFFFFF, 32'h00000001, 10, 32'h00000000, 32'hFFFFFFFF};
        vecs[14] = '{"div_m5_0",       3'd3, 32'hFFFFFFFB, 32'h00000000, 10, 32'h00000000, 32'hFFFFFFFF};

        rst   = 1'b0;
        Start = 1'b0;
        MDOp  = 3'd0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        prev_hi = '0;
        prev_lo = '0;
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].cycles > 0) begin
                chk({vecs[i].name, "_midrun_hi"}, {32'd0, HI}, {32'd0, prev_hi});
                chk({vecs[i].name, "_midrun_lo"}, {32'd0, LO}, {32'd0, prev_lo});
            end
            count_busy(cyc);
            chk({vecs[i].name, "_busy_cycles"}, 64'(cyc), 64'(vecs[i].cycles));
            chk({vecs[i].name, "_hi"}, {32'd0, HI}, {32'd0, vecs[i].exp_hi});
            chk({vecs[i].name, "_lo"}, {32'd0, LO}, {32'd0, vecs[i].exp_lo});
            $display("vec %0d %s op=%0d a=0x%h b=0x%h busy=%0d HI=0x%h LO=0x%h",
                     i, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, cyc, HI, LO);
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end

        // MTLO and a second MULT issued while a DIVU runs must both be dropped.
        issue(3'd4, 32'd100, 32'd7);
        cyc   = 1;
        guard = 0;
        while (Busy === 1'b1 && guard < 40) begin
            guard++;
            if (cyc == 2) begin
                Start = 1'b1; MDOp = 3'd6; SrcA = 32'h55;
            end else if (cyc == 4) begin
                Start = 1'b1; MDOp = 3'd1; SrcA = 32'd3; SrcB = 32'd3;
            end else begin
                Start = 1'b0; MDOp = 3'd0;
            end
            @(negedge clk);
            if (cyc == 2) chk("mtlo_mid_div_lo", {32'd0, LO}, 64'hFFFFFFFF);
            if (Busy === 1'b1) cyc++;
        end
        Start = 1'b0;
        chk("mid_run_busy_cycles", 64'(cyc), 64'd10);
        chk("mid_run_hi", {32'd0, HI}, 64'd2);
        chk("mid_run_lo", {32'd0, LO}, 64'hE);
        @(negedge clk);
        chk("ignored_mult_busy", {63'd0, Busy}, 64'd0);
        $display("seq mid-run ignore: busy=%0d HI=0x%h LO=0x%h", cyc, HI, LO);

        // Start on the very edge that clears Busy is ignored.
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(negedge clk);
        chk("same_edge_last_busy", {63'd0, Busy}, 64'd1);
        issue(3'd5, 32'h0000AAAA, 32'd0);
        chk("same_edge_busy_clear", {63'd0, Busy}, 64'd0);
        chk("same_edge_hi", {32'd0, HI}, 64'hFFFFFFFF);
        chk("same_edge_lo", {32'd0, LO}, 64'hFFFFFFFD);
        @(negedge clk);
        chk("same_edge_hi_hold", {32'd0, HI}, 64'hFFFFFFFF);
        $display("seq same-edge start: HI=0x%h LO=0x%h", HI, LO);

        // Asynchronous reset in cycle 3 of a divide discards the result.
        issue(3'd4, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, Busy}, 64'd0);
        chk("async_rst_hi", {32'd0, HI}, 64'd0);
        chk("async_rst_lo", {32'd0, LO}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(3'd5, 32'h00001234, 32'd0);
        chk("post_rst_first_cmd_hi", {32'd0, HI}, 64'h1234);
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {63'd0, Busy}, 64'd0);
        chk("post_rst_lo", {32'd0, LO}, 64'd0);
        chk("post_rst_hi_hold", {32'd0, HI}, 64'h1234);
        $display("seq async reset: Busy=%0b HI=0x%h LO=0x%h", Busy, HI, LO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 Parameter MULT_CYCLES, default 5, Busy duration of MULT/MULTU; legal range 1..15.
REQ-003 Parameter DIV_CYCLES, default 10, Busy duration of DIV/DIVU; legal range 1..15.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port Start  input  1  qualifies MDOp for one cycle.
REQ-007 Port MDOp  input  3  operation: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 Port SrcA  input  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-009 Port SrcB  input  WIDTH  rt operand (divisor, multiplier).
REQ-010 Port Busy  output  1  registered; high while a multiply or divide is in flight.
REQ-011 Port HI  output  WIDTH  architectural HI register.
REQ-012 Port LO  output  WIDTH  architectural LO register.

Function
REQ-013 A command is accepted when Start=1 at a rising edge with Busy=0; a command is ignored when Start=1 with Busy=1.
REQ-014 MULT/MULTU acceptance latches the full 2*WIDTH product (signed/unsigned) into an internal pending register.
REQ-015 DIV/DIVU acceptance latches the quotient (LO-bound) and remainder (HI-bound) into the pending register.
REQ-016 Signed divide truncates toward zero; remainder takes the sign of the dividend.
REQ-017 Signed divide of most-negative by -1: pending LO = most-negative, HI = 0.
REQ-018 Divisor of 0 (either signedness): operation runs full DIV_CYCLES; HI and LO retain prior values.
REQ-019 Edge t0 accepts a mult/div command: Busy=1 after t0, counter = N-1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-020 Each following edge with counter>0 decrements the counter.
REQ-021 Edge with Busy=1 and counter=0 writes pending high half to HI and low half to LO and clears Busy; Busy therefore stays high exactly N cycles.
REQ-022 State machine: IDLE (Busy=0) -> RUN on accepted MULT/MULTU/DIV/DIVU; RUN -> IDLE on counter=0 edge; no other transitions.
REQ-023 MTHI/MTLO accepted in IDLE write SrcA to HI/LO at that edge, no Busy.
REQ-024 MTHI/MTLO ignored in RUN.
REQ-025 MDOp NONE or an unencoded value with Start=1 is a no-op.
REQ-026 A Start on the same edge that clears Busy is ignored; the issuing stage stalls while Busy|Start.
REQ-027 HI/LO outputs change only at the completing edge (REQ-021) or an MTHI/MTLO edge; never mid-run.
REQ-028 WIDTH rules: product is 2*WIDTH bits with no truncation; the counter is 4 bits.

Reset
REQ-029 rst=0 asynchronously forces HI=0, LO=0, Busy=0, counter=0, pending=0, state IDLE, including mid-run; the aborted result is discarded.
REQ-030 The first command is accepted at the first rising edge after rst deasserts.

Structure
REQ-031 The MDOp encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and the IDLE/RUN state constants belong in shared package mdu_defs, also used by ControlUnit.
REQ-032 The combinational signed/unsigned product/quotient/remainder logic is a natural single sub-module, mdu_arith; the FSM, counter and HI/LO registers live in mult_div_unit.

Verification
REQ-033 MULT SrcA=0xFFFFFFFE(-2), SrcB=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV -7/2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged after 10 cycles.
REQ-036 MTHI 0x1234 at idle -> next edge HI=0x1234; MTLO 0x55 issued mid-DIV -> LO unchanged by it; second MULT issued during Busy -> ignored.
REQ-037 DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-038 rst pulled low at cycle 3 of a DIV -> HI=LO=0 and Busy=0 immediately; no result written after release.
